// File: rtl/buttfly_pkg.sv
// rtl/buttfly_pkg.sv - shared constants, state type and operand packing for the butterfly pair feeder
package buttfly_pkg;

    localparam int W_DEF      = 4;
    localparam int STRIDE_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    // a lands in the low half so that pi0 = a[0] at the butterfly
    function automatic logic [2*W_DEF-1:0] pack_pair(input logic [W_DEF-1:0] a,
                                                     input logic [W_DEF-1:0] b);
        return {b, a};
    endfunction

endpackage

// File: rtl/buttfly_pair_buf.sv
// rtl/buttfly_pair_buf.sv - first-half sample store, sync write / async read on a shared index
module buttfly_pair_buf
    import buttfly_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(STRIDE)-1:0] idx,
    input  logic [W-1:0]              wr_data,
    output logic [W-1:0]              rd_data
);

    logic [W-1:0] mem [STRIDE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/buttfly_pair_feeder.sv
// rtl/buttfly_pair_feeder.sv - pairs sample k with k+STRIDE into a registered operand word
module buttfly_pair_feeder
    import buttfly_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_pi,
    output logic           blk_done
);

    localparam int            IW       = $clog2(STRIDE);
    localparam logic [IW-1:0] IDX_LAST = IW'(STRIDE - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  rd_data;
    logic          in_xfer;

    // FILL never stalls: the held pair can drain while the next block fills
    assign in_ready = (state == FILL) || !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;

    buttfly_pair_buf #(
        .W      (W),
        .STRIDE (STRIDE)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_xfer && (state == FILL)),
        .idx     (idx),
        .wr_data (in_data),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            out_valid <= 1'b0;
            out_pi    <= '0;
            blk_done  <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_xfer) begin
                idx <= idx + 1'b1;
                if (state == PAIR) begin
                    out_pi    <= pack_pair(rd_data, in_data);
                    out_valid <= 1'b1;
                    if (idx == IDX_LAST) begin
                        state    <= FILL;
                        blk_done <= 1'b1;
                    end
                end else if (idx == IDX_LAST) begin
                    state <= PAIR;
                end
            end
        end
    end

endmodule

// File: tb/tb_buttfly_pair_feeder.sv
// tb/tb_buttfly_pair_feeder.sv - self-checking bench for buttfly_pair_feeder
module tb_buttfly_pair_feeder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_pi;
    logic       blk_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 1'b0;

    buttfly_pair_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pi    (out_pi),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: block position, stored first half, pending pairs
    int         cnt = 0;
    logic [3:0] first_half [S];
    logic [7:0] pend [$];
    logic [7:0] got [$];
    logic [7:0] last_pi = 8'h00;
    logic       exp_done = 1'b0;
    logic       s_ix = 1'b0, s_or = 1'b0;
    logic [3:0] s_d = 4'h0;
    logic [7:0] s_pi = 8'h00;

    always @(negedge clk) begin
        s_ix = in_valid && in_ready && rst_n;
        s_d  = in_data;
        s_or = out_ready;
        s_pi = out_pi;
        if (!rst_n) begin
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_out_pi", {24'b0, out_pi}, 0);
        end else begin
            chk("out_valid", {31'b0, out_valid}, (pend.size() > 0) ? 1 : 0);
            chk("out_pi", {24'b0, out_pi}, {24'b0, (pend.size() > 0) ? pend[0] : last_pi});
            chk("blk_done", {31'b0, blk_done}, {31'b0, exp_done});
            chk("in_ready", {31'b0, in_ready},
                (cnt < S || pend.size() == 0 || out_ready) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            cnt      = 0;
            last_pi  = 8'h00;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (s_or && pend.size() > 0) begin
                got.push_back(s_pi);
                void'(pend.pop_front());
            end
            if (s_ix) begin
                if (cnt < S) begin
                    first_half[cnt] = s_d;
                end else begin
                    last_pi = {s_d, first_half[cnt-S]};
                    pend.push_back(last_pi);
                    if (cnt == 2*S-1) exp_done = 1'b1;
                end
                cnt = (cnt + 1) % (2*S);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [3:0] d, output int waited);
        logic ok;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = in_ready;
            waited++;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic chk_got(input string name, input int i, input logic [7:0] exp);
        if (got.size() > i) chk(name, {24'b0, got[i]}, {24'b0, exp});
        else chk({name, "_missing"}, got.size(), i + 1);
    endtask

    logic [3:0] smp [1000];

    initial begin
        int w;
        int b;
        int k;
        logic [7:0] e;

        // reset state and the basic block
        do_reset();
        chk("reset_in_ready", {31'b0, in_ready}, 1);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_out_pi", {24'b0, out_pi}, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(4'(i), w);
        chk("t1_fill_no_valid", {31'b0, out_valid}, 0);
        send(4'd5, w);
        chk("t1_lat_valid", {31'b0, out_valid}, 1);
        chk("t1_pair0", {24'b0, out_pi}, 8'h51);
        send(4'd6, w);
        chk("t1_pair1", {24'b0, out_pi}, 8'h62);
        chk("t1_no_bubble", {31'b0, out_valid}, 1);
        send(4'd7, w);
        chk("t1_pair2", {24'b0, out_pi}, 8'h73);
        chk("t1_done_early", {31'b0, blk_done}, 0);
        send(4'd8, w);
        chk("t1_pair3", {24'b0, out_pi}, 8'h84);
        chk("t1_done", {31'b0, blk_done}, 1);
        tick();
        chk("t1_done_pulse", {31'b0, blk_done}, 0);
        chk_got("t1_got0", 0, 8'h51);
        chk_got("t1_got1", 1, 8'h62);
        chk_got("t1_got2", 2, 8'h73);
        chk_got("t1_got3", 3, 8'h84);

        // backpressure after the first pair
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(4'(i), w);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd6;
        repeat (4) tick();
        chk("t2_stall_ready", {31'b0, in_ready}, 0);
        chk("t2_hold_valid", {31'b0, out_valid}, 1);
        chk("t2_hold_pi", {24'b0, out_pi}, 8'h51);
        out_ready = 1'b1;
        for (int i = 6; i <= 8; i++) send(4'(i), w);
        repeat (2) tick();
        chk("t2_count", got.size(), 4);
        chk_got("t2_got0", 0, 8'h51);
        chk_got("t2_got1", 1, 8'h62);
        chk_got("t2_got2", 2, 8'h73);
        chk_got("t2_got3", 3, 8'h84);

        // back-to-back blocks, 84 held through the next FILL
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(4'(i), w);
        out_ready = 1'b0;
        for (int i = 9; i <= 12; i++) begin
            send(4'(i), w);
            chk("t3_fill_no_stall", w, 1);
        end
        chk("t3_held_pi", {24'b0, out_pi}, 8'h84);
        out_ready = 1'b1;
        send(4'd13, w);
        chk("t3_simul_valid", {31'b0, out_valid}, 1);
        chk("t3_simul_pi", {24'b0, out_pi}, 8'hD9);
        for (int i = 14; i <= 16; i++) send(4'(i), w);
        repeat (2) tick();
        chk_got("t3_got3", 3, 8'h84);
        chk_got("t3_got4", 4, 8'hD9);
        chk_got("t3_got5", 5, 8'hEA);
        chk_got("t3_got6", 6, 8'hFB);
        chk_got("t3_got7", 7, 8'h0C);

        // reset in the middle of a block
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) send(4'(i), w);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, out_valid}, 0);
        chk("t5_rst_pi", {24'b0, out_pi}, 0);
        tick();
        rst_n = 1'b1;
        got.delete();
        for (int i = 10; i <= 17; i++) send(4'(i), w);
        repeat (2) tick();
        chk_got("t5_first", 0, 8'hEA);
        chk("t5_count", got.size(), 4);

        // random valid/ready over 1000 samples
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            smp[i] = 4'($urandom_range(0, 15));
            send(smp[i], w);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_count", got.size(), 500);
        for (int j = 0; j < 500 && j < got.size(); j++) begin
            b = j / S;
            k = j % S;
            e = {smp[2*S*b + S + k], smp[2*S*b + k]};
            if (got[j] !== e) chk("rand_pair", {24'b0, got[j]}, {24'b0, e});
        end
        chk("rand_pairs_seen", (got.size() >= 500) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got %0d pairs", got.size());
        $fatal(1, "watchdog");
    end

endmodule
